op_input_stage: RTL

OP_INPUT_STAGE -- requirements
Module: op_input_stage

---
 rtl/op_input_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/op_input_stage.sv
`default_nettype none
// ============================================================================
// Module   : op_input_stage
// Brief    : Synchronizes operand/mode switches and a bouncing push button,
//            debounces the button and latches an operand set per press with a
//            valid/ready handshake. Optional macro OP_INPUT_AUTO_REPEAT_EN
//            adds auto-repeat press events while the button is held.
// Revision : 1.0 - initial release
// ============================================================================
module op_input_stage #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_z,
    input  logic [3:0] sw_y,
    input  logic [1:0] sw_mode,
    input  logic       btn_n,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] Z,
    output logic [3:0] Y,
    output logic [1:0] mode,
    output logic       btn_change,
    output logic       overrun
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    // Packed as {btn_n, mode, y, z}; the button idles high through reset.
    localparam logic [10:0] SYNC_RST = 11'b100_0000_0000;

    logic [10:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       z_q, z_d, y_q, y_d;
    logic [1:0]       mode_q, mode_d;
    logic             overrun_q, overrun_d;
    logic             w_btn_s;
    logic             w_press_evt;
    logic             w_rpt_evt;
    logic             w_evt;

    assign w_btn_s = sync2_q[10];

    always_comb begin
        sync1_d     = {btn_n, sw_mode, sw_y, sw_z};
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_press_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (!w_btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (w_btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    w_press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (w_btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (!w_btn_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef OP_INPUT_AUTO_REPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    // Only cycles that stay in PRESSED accumulate; any exit clears the count.
    always_comb begin
        rpt_cnt_d = '0;
        w_rpt_evt = 1'b0;
        if (state_q == PRESSED && state_d == PRESSED) begin
            if (rpt_cnt_q == RPT_LAST) begin
                w_rpt_evt = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    logic w_unused_rpt;
    assign w_unused_rpt = (REPEAT_CYCLES == 0);
    assign w_rpt_evt    = 1'b0;
`endif

    assign w_evt = w_press_evt | w_rpt_evt;

    // A press landing on an accepting edge is still dropped: the decision
    // uses the valid flag as it was before the edge.
    always_comb begin
        out_valid_d = out_valid_q & ~out_ready;
        z_d         = z_q;
        y_d         = y_q;
        mode_d      = mode_q;
        overrun_d   = overrun_q;
        if (w_evt) begin
            if (!out_valid_q) begin
                z_d         = sync2_q[3:0];
                y_d         = sync2_q[7:4];
                mode_d      = sync2_q[9:8];
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= SYNC_RST;
            sync2_q     <= SYNC_RST;
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            z_q         <= 4'h0;
            y_q         <= 4'h0;
            mode_q      <= 2'b00;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign Z          = z_q;
    assign Y          = y_q;
    assign mode       = mode_q;
    assign overrun    = overrun_q;
    assign btn_change = ~((state_q == PRESSED) || (state_q == RELEASE_WAIT));

endmodule
`default_nettype wire
